pixel_ray_scheduler: RTL and testbench

//  Frame-level pixel issuer directly upstream of eye_to_pixel. On a frame request it snapshots the

---
 rtl/ray_pkg.sv | 20 ++
 rtl/ray_credit_counter.sv | 49 ++++
 rtl/pixel_ray_scheduler.sv | 144 ++++++++++++++
 tb/tb_pixel_ray_scheduler.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_pkg.sv
// Shared types and defaults for the pixel ray path.
//   state_t      : frame scheduler states
//   float32_t    : raw IEEE-754 single-precision word, carried but never interpreted here
//   DEF_*_PIXELS : default frame geometry, shared with eye_to_pixel
package ray_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  typedef logic [31:0] float32_t;

  localparam int DEF_H_PIXELS = 1280;
  localparam int DEF_V_PIXELS = 720;

endpackage

// File: rtl/ray_credit_counter.sv
// In-flight ray credit counter.
//   clk_in, rst_in : clock, synchronous active-high reset
//   issue          : a ray is issued this cycle (ignored when full)
//   retire         : a ray retired downstream this cycle
//   count          : rays issued but not yet retired
//   full / empty   : count == MAX_INFLIGHT / count == 0
//   err            : sticky; a retire arrived with nothing in flight
module ray_credit_counter #(
  parameter int MAX_INFLIGHT = 16,
  localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          issue,
  input  logic          retire,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err
);

  logic inc;
  logic dec;

  assign full  = (count == CW'(MAX_INFLIGHT));
  assign empty = (count == '0);

  // A retire with nothing in flight is dropped (count saturates at 0), so a
  // simultaneous issue still takes its credit.
  assign inc = issue && !full;
  assign dec = retire && !empty;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in the design sees the pre-edge values of its neighbours.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (retire && empty) err <= 1'b1;
      case ({inc, dec})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_ray_scheduler.sv
// Frame-level pixel issuer feeding eye_to_pixel.
// On an accepted frame_start_in it snapshots the head position, then issues
// every (x,y) of the frame once in raster order, throttled by in-flight credits.
//   clk_in, rst_in           : clock, synchronous active-high reset
//   frame_start_in           : 1-cycle frame request, honoured only when idle
//   head_{x,y,z}_in          : head position, sampled on an accepted start
//   stall_in                 : level; blocks issue while high
//   retire_in                : 1-cycle pulse returning one credit
//   x_out, y_out             : issued pixel, qualified by valid_out
//   head_{x,y,z}_float       : head position held for the whole frame
//   valid_out                : 1-cycle issue strobe
//   busy_out                 : frame in progress (LATCH through DRAIN)
//   frame_done_out           : 1-cycle pulse once the last ray has retired
//   credit_err_out           : sticky retire-underflow flag
module pixel_ray_scheduler
  import ray_pkg::*;
#(
  parameter int H_PIXELS     = DEF_H_PIXELS,
  parameter int V_PIXELS     = DEF_V_PIXELS,
  parameter int X_BITS       = 11,
  parameter int Y_BITS       = 10,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start_in,
  input  float32_t          head_x_in,
  input  float32_t          head_y_in,
  input  float32_t          head_z_in,
  input  logic              stall_in,
  input  logic              retire_in,
  output logic [X_BITS-1:0] x_out,
  output logic [Y_BITS-1:0] y_out,
  output float32_t          head_x_float,
  output float32_t          head_y_float,
  output float32_t          head_z_float,
  output logic              valid_out,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic              credit_err_out
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(H_PIXELS - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(V_PIXELS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [X_BITS-1:0] x_cnt;
  logic [Y_BITS-1:0] y_cnt;
  logic [CW-1:0]     inflight;
  logic              credit_full;
  logic              credit_empty;
  logic              issue;
  logic              last_pixel;

  // Issue decision uses the registered credit count, so a retire in the same
  // cycle never lets a full counter issue.
  assign issue      = (state == SCAN) && !stall_in && !credit_full;
  assign last_pixel = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

  ray_credit_counter #(
    .MAX_INFLIGHT(MAX_INFLIGHT)
  ) u_credit (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .issue  (issue),
    .retire (retire_in),
    .count  (inflight),
    .full   (credit_full),
    .empty  (credit_empty),
    .err    (credit_err_out)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    busy_out       = 1'b0;
    frame_done_out = 1'b0;
    case (state)
      IDLE:  if (frame_start_in) state_nxt = LATCH;
      LATCH: begin
        busy_out  = 1'b1;
        state_nxt = SCAN;
      end
      SCAN: begin
        busy_out = 1'b1;
        if (issue && last_pixel) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy_out = 1'b1;
        if (credit_empty) state_nxt = DONE;
      end
      DONE: begin
        frame_done_out = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      x_cnt        <= '0;
      y_cnt        <= '0;
      x_out        <= '0;
      y_out        <= '0;
      valid_out    <= 1'b0;
      head_x_float <= '0;
      head_y_float <= '0;
      head_z_float <= '0;
    end else begin
      state     <= state_nxt;
      valid_out <= issue;

      if (state == IDLE && frame_start_in) begin
        head_x_float <= head_x_in;
        head_y_float <= head_y_in;
        head_z_float <= head_z_in;
      end

      if (state == LATCH) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (issue) begin
        x_out <= x_cnt;
        y_out <= y_cnt;
        // y runs one past the last line after the final issue; LATCH clears it.
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + Y_BITS'(1);
        end else begin
          x_cnt <= x_cnt + X_BITS'(1);
        end
      end
    end
  end

  a_inflight_bound : assert property (@(posedge clk_in) disable iff (rst_in)
    inflight <= CW'(MAX_INFLIGHT));

endmodule

// File: tb/tb_pixel_ray_scheduler.sv
// Two schedulers on one clock: A (4x3, 16 credits, retire = valid delayed
// 5 cycles) and B (4x3, 2 credits, bench-driven retires). A frame-level
// reference model predicts every output of both after every clock edge.
module tb_pixel_ray_scheduler;

  localparam int H = 4;
  localparam int V = 3;
  localparam int N = H * V;
  localparam int MAXI [2] = '{16, 2};

  logic        clk = 1'b0;
  logic        rst_s    [2];
  logic        start_s  [2];
  logic        stall_s  [2];
  logic        retire_s [2];
  logic [31:0] hx_s [2], hy_s [2], hz_s [2];

  logic [1:0]  x_o [2], y_o [2];
  logic [31:0] hxo [2], hyo [2], hzo [2];
  logic        valid_o [2], busy_o [2], done_o [2], err_o [2];

  always #5 clk = ~clk;

  pixel_ray_scheduler #(
    .H_PIXELS(H), .V_PIXELS(V), .X_BITS(2), .Y_BITS(2), .MAX_INFLIGHT(16)
  ) dut_a (
    .clk_in(clk), .rst_in(rst_s[0]), .frame_start_in(start_s[0]),
    .head_x_in(hx_s[0]), .head_y_in(hy_s[0]), .head_z_in(hz_s[0]),
    .stall_in(stall_s[0]), .retire_in(retire_s[0]),
    .x_out(x_o[0]), .y_out(y_o[0]),
    .head_x_float(hxo[0]), .head_y_float(hyo[0]), .head_z_float(hzo[0]),
    .valid_out(valid_o[0]), .busy_out(busy_o[0]),
    .frame_done_out(done_o[0]), .credit_err_out(err_o[0])
  );

  pixel_ray_scheduler #(
    .H_PIXELS(H), .V_PIXELS(V), .X_BITS(2), .Y_BITS(2), .MAX_INFLIGHT(2)
  ) dut_b (
    .clk_in(clk), .rst_in(rst_s[1]), .frame_start_in(start_s[1]),
    .head_x_in(hx_s[1]), .head_y_in(hy_s[1]), .head_z_in(hz_s[1]),
    .stall_in(stall_s[1]), .retire_in(retire_s[1]),
    .x_out(x_o[1]), .y_out(y_o[1]),
    .head_x_float(hxo[1]), .head_y_float(hyo[1]), .head_z_float(hzo[1]),
    .valid_out(valid_o[1]), .busy_out(busy_o[1]),
    .frame_done_out(done_o[1]), .credit_err_out(err_o[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a frame is a count of issued pixels plus credits.
  int          m_active [2], m_age [2], m_issued [2], m_infl [2];
  int          m_done [2], m_err [2], m_valid [2], m_x [2], m_y [2];
  logic [31:0] m_hx [2], m_hy [2], m_hz [2];
  bit          vh [5];
  bit          ret_en_a = 1'b1;

  task automatic model_reset(input int d);
    m_active[d] = 0; m_age[d] = 0; m_issued[d] = 0; m_infl[d] = 0;
    m_done[d] = 0; m_err[d] = 0; m_valid[d] = 0; m_x[d] = 0; m_y[d] = 0;
    m_hx[d] = '0; m_hy[d] = '0; m_hz[d] = '0;
  endtask

  task automatic model_edge(input int d);
    int iss;
    iss = 0;
    if (rst_s[d]) begin
      model_reset(d);
      return;
    end
    if (m_active[d] == 0) begin
      if (start_s[d]) begin
        m_active[d] = 1; m_age[d] = 0; m_issued[d] = 0;
        m_hx[d] = hx_s[d]; m_hy[d] = hy_s[d]; m_hz[d] = hz_s[d];
      end
    end else begin
      if (m_done[d] != 0) begin
        m_active[d] = 0;
        m_done[d]   = 0;
      end else if (m_issued[d] == N && m_infl[d] == 0) begin
        m_done[d] = 1;
      end else if (m_age[d] >= 1 && m_issued[d] < N && !stall_s[d] && m_infl[d] < MAXI[d]) begin
        iss = 1;
        m_x[d] = m_issued[d] % H;
        m_y[d] = m_issued[d] / H;
        m_issued[d]++;
      end
      m_age[d]++;
    end
    if (retire_s[d]) begin
      if (m_infl[d] == 0) m_err[d] = 1;
      else m_infl[d]--;
    end
    m_infl[d] += iss;
    m_valid[d] = iss;
  endtask

  task automatic check_dut(input int d);
    string nm;
    nm = (d == 0) ? "a" : "b";
    check({nm, "_valid"}, 64'(valid_o[d]), 64'(m_valid[d] != 0));
    check({nm, "_x"},     64'(x_o[d]),     64'(m_x[d]));
    check({nm, "_y"},     64'(y_o[d]),     64'(m_y[d]));
    check({nm, "_busy"},  64'(busy_o[d]),  64'(m_active[d] != 0 && m_done[d] == 0));
    check({nm, "_done"},  64'(done_o[d]),  64'(m_done[d] != 0));
    check({nm, "_err"},   64'(err_o[d]),   64'(m_err[d] != 0));
    check({nm, "_hx"},    64'(hxo[d]),     64'(m_hx[d]));
    check({nm, "_hy"},    64'(hyo[d]),     64'(m_hy[d]));
    check({nm, "_hz"},    64'(hzo[d]),     64'(m_hz[d]));
  endtask

  // One clock: model follows the edge, outputs are checked on the falling
  // edge, and A's retire is refreshed from its 5-deep valid history.
  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    cyc++;
    for (int i = 4; i > 0; i--) vh[i] = vh[i-1];
    vh[0] = (m_valid[0] != 0);
    if (rst_s[0]) for (int i = 0; i < 5; i++) vh[i] = 1'b0;
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    retire_s[0] = vh[4] && ret_en_a;
  endtask

  task automatic pulse_start(input int d, input logic [31:0] hx);
    start_s[d] = 1'b1;
    hx_s[d] = hx; hy_s[d] = $urandom; hz_s[d] = $urandom;
    step();
    start_s[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input string tag);
    int n;
    n = 0;
    while ((m_active[d] != 0 || busy_o[d]) && n < 200) begin
      if (d == 1) retire_s[1] = (m_infl[1] > 0) && ($urandom_range(0, 1) == 1);
      step();
      n++;
    end
    retire_s[1] = 1'b0;
    check(tag, 64'(busy_o[d]), 64'(0));
  endtask

  initial begin
    int t0, first, last, nv, nd;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; start_s[d] = 1'b0; stall_s[d] = 1'b0; retire_s[d] = 1'b0;
      hx_s[d] = '0; hy_s[d] = '0; hz_s[d] = '0;
      model_reset(d);
    end
    for (int i = 0; i < 5; i++) vh[i] = 1'b0;
    repeat (3) step();
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    step();
    check("reset_busy", 64'(busy_o[0]), 64'(0));
    check("reset_valid", 64'(valid_o[1]), 64'(0));

    // Frame timing: 12 valids on T+2..T+13 then one done pulse.
    start_s[0] = 1'b1; hx_s[0] = 32'h3F80_0000;
    step();
    t0 = cyc;
    start_s[0] = 1'b0;
    first = -1; last = -1; nv = 0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid_o[0]) begin
        if (first < 0) first = cyc;
        last = cyc;
        nv++;
      end
      if (done_o[0]) nd++;
    end
    check("t1_first_lat", 64'(first - t0), 64'(2));
    check("t1_last_lat", 64'(last - t0), 64'(13));
    check("t1_count", 64'(nv), 64'(12));
    check("t1_done", 64'(nd), 64'(1));

    // Credit limit of 2 with no retires.
    pulse_start(1, 32'h1234_5678);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (valid_o[1]) nv++;
    end
    check("t2_two_valids", 64'(nv), 64'(2));
    retire_s[1] = 1'b1;
    step();
    retire_s[1] = 1'b0;
    step();
    check("t2_one_more", 64'(valid_o[1]), 64'(1));
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (valid_o[1]) nv++;
    end
    check("t2_stalled_again", 64'(nv), 64'(0));
    wait_idle(1, "t2_idle");

    // Head snapshot held while the input keeps changing.
    pulse_start(0, 32'h44E1_0001);
    for (int i = 0; i < 25; i++) begin
      hx_s[0] = $urandom;
      step();
      check("t3_head_hold", 64'(hxo[0]), 64'h44E1_0001);
    end
    wait_idle(0, "t3_idle");

    // Stall for 10 cycles just before pixel (2,1).
    pulse_start(0, 32'h4000_0000);
    nv = 0;
    while (m_issued[0] != 6 && nv < 50) begin
      step();
      nv++;
    end
    check("t4_reach_x2", 64'(m_issued[0]), 64'(6));
    stall_s[0] = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid_o[0]) nv++;
    end
    check("t4_no_valid_stalled", 64'(nv), 64'(0));
    stall_s[0] = 1'b0;
    step();
    check("t4_resume_valid", 64'(valid_o[0]), 64'(1));
    check("t4_resume_x", 64'(x_o[0]), 64'(2));
    check("t4_resume_y", 64'(y_o[0]), 64'(1));
    wait_idle(0, "t4_idle");

    // Retire with nothing in flight.
    retire_s[1] = 1'b1;
    step();
    retire_s[1] = 1'b0;
    step();
    check("t5_err_set", 64'(err_o[1]), 64'(1));
    repeat (5) step();
    check("t5_err_sticky", 64'(err_o[1]), 64'(1));

    // Reset mid-scan on A; start while busy on B.
    pulse_start(0, 32'h4040_0000);
    nv = 0;
    while (m_issued[0] < 5 && nv < 50) begin
      step();
      nv++;
    end
    rst_s[0] = 1'b1;
    step();
    rst_s[0] = 1'b0;
    check("t6_rst_valid", 64'(valid_o[0]), 64'(0));
    check("t6_rst_busy", 64'(busy_o[0]), 64'(0));
    check("t6_rst_x", 64'(x_o[0]), 64'(0));
    check("t6_rst_head", 64'(hxo[0]), 64'(0));
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done_o[0]) nd++;
    end
    check("t6_no_done", 64'(nd), 64'(0));
    pulse_start(1, 32'hAAAA_5555);
    step();
    pulse_start(1, 32'h0F0F_0F0F);
    check("t6_busy_start_ignored", 64'(hxo[1]), 64'hAAAA_5555);
    wait_idle(1, "t6_idle");

    // Random traffic on both: stalls, retires, stray starts, changing heads.
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < 2; d++) begin
        start_s[d] = ($urandom_range(0, 7) == 0);
        stall_s[d] = ($urandom_range(0, 3) == 0);
        hx_s[d] = $urandom; hy_s[d] = $urandom; hz_s[d] = $urandom;
      end
      retire_s[1] = (m_infl[1] > 0) && ($urandom_range(0, 2) != 0);
      step();
    end
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      stall_s[d] = 1'b0;
    end
    wait_idle(0, "rand_idle_a");
    wait_idle(1, "rand_idle_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
